// File: rtl/lc3_hazard_ctrl_pkg.sv
// Shared LC-3 decode helpers: opcodes, hazard FSM states and source-register
// extraction. The forwarding unit imports the same package.
package lc3_pkg;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RES  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  // RUN: normal flow; MEM_WAIT: first/only data access outstanding;
  // MEM_IND: second (indirect) access of LDI/STI outstanding.
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_MEM_IND  = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic       uses_sr1;
    logic [2:0] sr1;
    logic       uses_sr2;
    logic [2:0] sr2;
  } src_regs_t;

  function automatic logic is_load(input logic [3:0] op);
    return (op == OP_LD) || (op == OP_LDR) || (op == OP_LDI);
  endfunction

  function automatic logic is_memop(input logic [3:0] op);
    return is_load(op) || (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
  endfunction

  function automatic logic is_ind(input logic [3:0] op);
    return (op == OP_LDI) || (op == OP_STI);
  endfunction

  // Which registers an instruction reads. Stores read their data register
  // from [11:9]; that field goes into the sr2 slot.
  function automatic src_regs_t src_regs(input logic [15:0] ir);
    src_regs_t s;
    logic      unused_ok;
    unused_ok  = ^ir[4:3];
    s          = '0;
    s.sr1      = ir[8:6];
    s.sr2      = ir[11:9];
    case (ir[15:12])
      OP_ADD, OP_AND: begin
        s.uses_sr1 = 1'b1;
        s.uses_sr2 = ~ir[5];
        s.sr2      = ir[2:0];
      end
      OP_NOT, OP_LDR, OP_JMP: s.uses_sr1 = 1'b1;
      OP_JSR:                 s.uses_sr1 = ~ir[11];
      OP_STR: begin
        s.uses_sr1 = 1'b1;
        s.uses_sr2 = 1'b1;
      end
      OP_ST, OP_STI:          s.uses_sr2 = 1'b1;
      default: ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/lc3_hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle. The pipeline (master) presents the
// stage instructions and memory status; the controller (slave) returns the
// register enables, bubbles, flush and status. All signals are level-valued
// per cycle: there is no valid/ready handshake, mem_ready simply marks the
// cycle in which the data memory completes the current access.
interface lc3_hazard_if #(
  parameter int IR_W  = 16,
  parameter int CNT_W = 16
);
  import lc3_pkg::*;

  logic [IR_W-1:0]  ifid_ir;
  logic [IR_W-1:0]  idex_ir;
  logic [IR_W-1:0]  exmem_ir;
  logic             mem_ready;
  logic             branch_taken;

  logic             pc_we;
  logic             ifid_we;
  logic             idex_we;
  logic             exmem_we;
  logic             idex_bubble;
  logic             memwb_bubble;
  logic             flush;
  logic             mem_phase;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  hz_state_e        state;

  modport master (
    output ifid_ir, idex_ir, exmem_ir, mem_ready, branch_taken,
    input  pc_we, ifid_we, idex_we, exmem_we, idex_bubble, memwb_bubble,
    input  flush, mem_phase, mem_err, stall_cnt, state
  );

  modport slave (
    input  ifid_ir, idex_ir, exmem_ir, mem_ready, branch_taken,
    output pc_we, ifid_we, idex_we, exmem_we, idex_bubble, memwb_bubble,
    output flush, mem_phase, mem_err, stall_cnt, state
  );

endinterface

// File: rtl/lc3_hazard_ctrl_src_decode.sv
// Source-register extraction for the instruction in ID and comparison against
// a producing destination register (the load in EX).
module lc3_src_decode
  import lc3_pkg::*;
(
  input  logic [15:0] ir_i,
  input  logic [2:0]  dst_i,
  input  logic        dst_vld_i,
  output src_regs_t   src_o,
  output logic        hit_o
);

  // Decode sources, then flag a hit if any used source matches dst_i.
  always_comb begin
    src_o = src_regs(ir_i);
    hit_o = dst_vld_i &&
            ((src_o.uses_sr1 && (src_o.sr1 == dst_i)) ||
             (src_o.uses_sr2 && (src_o.sr2 == dst_i)));
  end

endmodule

// File: rtl/lc3_hazard_ctrl.sv
// Stall/flush controller for the 5-stage LC-3 pipeline: branch squash,
// memory freeze (including LDI/STI second access) with timeout, load-use
// bubble, and a saturating stall-cycle counter.
module lc3_hazard_ctrl
  import lc3_pkg::*;
#(
  parameter int IR_W        = 16,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input logic        clk,
  input logic        rst_n,
  lc3_hazard_if.slave hz
);

  localparam int TMR_W = $clog2(MEM_TIMEOUT + 1);

  hz_state_e        state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             mem_err_q;
  logic             err_set;

  logic [3:0]       ex_op;
  logic [3:0]       mem_op;
  logic             load_use;
  src_regs_t        ifid_src;

  logic             frz;       // memory freeze this cycle
  logic             lu_stall;  // one-cycle load-use bubble this cycle
  logic             flush_c;
  logic             phase_c;

  assign ex_op  = hz.idex_ir[15:12];
  assign mem_op = hz.exmem_ir[15:12];

  wire unused_ok = ^{hz.idex_ir[8:0], hz.exmem_ir[11:0], ifid_src};

  lc3_src_decode u_src_decode (
    .ir_i      (hz.ifid_ir[15:0]),
    .dst_i     (hz.idex_ir[11:9]),
    .dst_vld_i (is_load(ex_op)),
    .src_o     (ifid_src),
    .hit_o     (load_use)
  );

  // Next-state logic: branch flush beats memory freeze beats load-use stall.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    err_set  = 1'b0;
    frz      = 1'b0;
    lu_stall = 1'b0;
    flush_c  = 1'b0;
    phase_c  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (hz.branch_taken) begin
          flush_c = 1'b1;
        end else if (is_memop(mem_op) && !hz.mem_ready) begin
          frz     = 1'b1;
          state_d = ST_MEM_WAIT;
          timer_d = TMR_W'(1);
        end else if (is_ind(mem_op) && hz.mem_ready) begin
          frz     = 1'b1;
          state_d = ST_MEM_IND;
          timer_d = '0;
        end else if (load_use) begin
          lu_stall = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (hz.mem_ready && is_ind(mem_op)) begin
          frz     = 1'b1;
          state_d = ST_MEM_IND;
          timer_d = '0;
        end else if (hz.mem_ready) begin
          state_d = ST_RUN;
          timer_d = '0;
        end else if (timer_q == TMR_W'(MEM_TIMEOUT)) begin
          err_set = 1'b1;
          state_d = ST_RUN;
          timer_d = '0;
        end else begin
          frz     = 1'b1;
          timer_d = timer_q + 1'b1;
        end
      end
      ST_MEM_IND: begin
        phase_c = 1'b1;
        if (hz.mem_ready) begin
          state_d = ST_RUN;
          timer_d = '0;
        end else if (timer_q == TMR_W'(MEM_TIMEOUT)) begin
          err_set = 1'b1;
          state_d = ST_RUN;
          timer_d = '0;
        end else begin
          frz     = 1'b1;
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Output decode; everything is held inactive while reset is asserted.
  always_comb begin
    hz.pc_we        = rst_n && !frz && !lu_stall;
    hz.ifid_we      = rst_n && !frz && !lu_stall;
    hz.idex_we      = rst_n && !frz;
    hz.exmem_we     = rst_n && !frz;
    hz.idex_bubble  = rst_n && lu_stall;
    hz.memwb_bubble = rst_n && frz;
    hz.flush        = rst_n && flush_c;
    hz.mem_phase    = rst_n && phase_c;
    hz.mem_err      = mem_err_q;
    hz.stall_cnt    = stall_cnt_q;
    hz.state        = state_q;
  end

  // State, timer, sticky error and saturating stall counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      timer_q     <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      if (err_set) begin
        mem_err_q <= 1'b1;
      end
      if ((frz || lu_stall) && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: doc/lc3_hazard_ctrl.md
Name: lc3_hazard_ctrl

Overview:
- Stall/flush controller for the 5-stage LC-3 pipeline; it is the companion to the operand-forwarding unit.
- Forwarding consumes results already produced in EX/MEM and MEM/WB. This block handles the cases that cannot be satisfied that way:
  - load-use hazards,
  - multi-cycle memory accesses, including the second access of LDI/STI,
  - taken-branch squash.
- Drives the write enables, bubbles and flushes of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, and keeps a saturating stall-cycle counter.

Parameters:
- IR_W, 16, instruction width.
- CNT_W, 16, width of the stall counter.
- MEM_TIMEOUT, 15, maximum cycles spent waiting for mem_ready before aborting the access.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  synchronous reset, active-low.
- ifid_ir  in  IR_W  instruction in ID.
- idex_ir  in  IR_W  instruction in EX.
- exmem_ir  in  IR_W  instruction in MEM.
- mem_ready  in  1  data memory completes the current access this cycle.
- branch_taken  in  1  redirect resolved for the exmem_ir instruction (BR taken, JMP, JSR/JSRR, TRAP).
- pc_we  out  1  PC update enable.
- ifid_we  out  1  IF/ID load enable.
- idex_we  out  1  ID/EX load enable.
- exmem_we  out  1  EX/MEM load enable.
- idex_bubble  out  1  load NOP into ID/EX.
- memwb_bubble  out  1  load NOP into MEM/WB.
- flush  out  1  squash IF/ID, ID/EX and EX/MEM contents.
- mem_phase  out  1  0 = first/only access, 1 = indirect second access of LDI/STI.
- mem_err  out  1  sticky flag, set on memory timeout.
- stall_cnt  out  CNT_W  total stall cycles.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state←RUN, timer←0, stall_cnt←0, mem_err←0.
  - While rst_n=0: all *_we=0, bubbles=0, flush=0, mem_phase=0.
- Opcode classes:
  - LOAD = {LD 0010, LDR 0110, LDI 1010}.
  - MEMOP = LOAD ∪ {ST 0011, STR 0111, STI 1011}.
  - IND = {LDI, STI}.
- Sources read by ifid_ir:
  - ADD/AND reg: [8:6] and [2:0].
  - ADD/AND imm, NOT, LDR, JMP, JSRR: [8:6].
  - STR: [11:9] and [8:6].
  - ST, STI: [11:9].
  - Everything else reads no register.
- load_use: idex_ir∈LOAD and any source of ifid_ir equals idex_ir[11:9].
- States: RUN, MEM_WAIT, MEM_IND.
- Priority per cycle: branch flush > memory freeze > load-use stall.
- RUN:
  - If branch_taken: flush=1, all *_we=1, no bubble. Resolved in 1 cycle; not counted as a stall.
  - Else if exmem_ir∈MEMOP and mem_ready=0: freeze.
    - pc_we, ifid_we, idex_we, exmem_we = 0; memwb_bubble=1.
    - Go to MEM_WAIT; timer←1.
  - Else if exmem_ir∈IND and mem_ready=1: same freeze; go to MEM_IND; timer←0.
  - Else if load_use:
    - pc_we=0, ifid_we=0, idex_bubble=1; exmem_we=1.
    - Exactly one bubble; the stalled instruction re-evaluates next cycle with the load now in MEM, where forwarding covers it.
  - Else all *_we=1.
- MEM_WAIT (mem_phase=0):
  - Freeze outputs held.
  - On mem_ready=1:
    - IND → MEM_IND, timer←0.
    - Non-IND: release this cycle (all we=1, memwb_bubble=0) and return to RUN.
  - timer increments each cycle. On timer==MEM_TIMEOUT: mem_err←1, release, return to RUN.
- MEM_IND (mem_phase=1):
  - Freeze held.
  - On mem_ready=1: release and go to RUN.
  - Same timeout rule.
- branch_taken while in MEM_WAIT/MEM_IND is ignored. The source cannot retire until the freeze ends; the EX/MEM-stage driver must hold it.
- stall_cnt increments every cycle in which pc_we=0 and rst_n=1; saturates at all-ones.
- mem_err clears only on reset.
- Reset mid-freeze returns to RUN with counters cleared. The memory side must drop any in-flight access on reset.

Decomposition:
- Package lc3_pkg:
  - opcode constants,
  - state enum,
  - functions is_load, is_memop, is_ind and src_regs (returns uses_sr1/sr1/uses_sr2/sr2).
  - The forwarding unit shares these.
- One sub-module, lc3_src_decode: combinational source-register extraction from ifid_ir.
- FSM, timer and counter stay in the top module.

Test Plan:
- LDR R1,R2,#0 in EX, ADD R3,R1,R4 in ID, memory ready immediately → exactly 1 cycle with pc_we=0, idex_bubble=1; ADD issues next cycle; stall_cnt=1.
- LDR R1 in EX, ADD R3,R2,#1 in ID (no dependency) → no stall; all we=1; stall_cnt=0.
- LD in MEM, mem_ready low for 3 cycles then high → freeze for 3 cycles, memwb_bubble=1 each; release on the 4th; stall_cnt=3; mem_phase=0 throughout.
- LDI in MEM, mem_ready high, then low 2 cycles, then high → state MEM_IND, mem_phase=1 on the second access; freeze lasts 3 cycles total.
- BRz taken in MEM together with a load-use in ID/EX → flush=1 wins; no idex_bubble; pc_we=1; stall_cnt unchanged.
- ST in MEM, mem_ready held low → on cycle MEM_TIMEOUT (15), mem_err=1 and the pipeline releases; mem_err stays 1 until rst_n=0, after which all counters read 0.
